// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit for a Mini SRC-style CPU: three fetch steps (T0-T2),
// up to five per-opcode execute steps (T3-T7), plus HALT and PAUSE parking states.
module control_sequencer #(
  parameter logic [4:0] ADD_OP  = 5'b00011,
  parameter logic [4:0] HALT_OP = 5'b11011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        run,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        OutPortin,
  output logic        CONin,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic [4:0]  opcode
);

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALT, PAUSE
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_NEGNOT, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP
  } cls_t;

  state_t      state_r;
  cls_t        cls_s;
  state_t      last_s;
  logic [4:0]  op_s;
  logic        ir_unused_s;

  assign op_s        = IR[31:27];
  assign ir_unused_s = ^IR[26:0];

  // Group opcodes into execute-sequence classes; nop and unassigned codes share C_NOP.
  always_comb begin
    case (op_s) inside
      HALT_OP:       cls_s = C_HALT;
      5'd0:          cls_s = C_LD;
      5'd1:          cls_s = C_LDI;
      5'd2:          cls_s = C_ST;
      [5'd3:5'd11]:  cls_s = C_ALU;
      [5'd12:5'd14]: cls_s = C_IMM;
      5'd15, 5'd16:  cls_s = C_MULDIV;
      5'd17, 5'd18:  cls_s = C_NEGNOT;
      5'd19:         cls_s = C_BR;
      5'd20:         cls_s = C_JR;
      5'd21:         cls_s = C_JAL;
      5'd22:         cls_s = C_IN;
      5'd23:         cls_s = C_OUT;
      5'd24:         cls_s = C_MFHI;
      5'd25:         cls_s = C_MFLO;
      default:       cls_s = C_NOP;
    endcase
  end

  // Final execute step of each instruction class.
  always_comb begin
    case (cls_s)
      C_ALU, C_IMM, C_LDI:              last_s = T5;
      C_LD, C_ST:                       last_s = T7;
      C_MULDIV, C_BR:                   last_s = T6;
      C_NEGNOT, C_JAL:                  last_s = T4;
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: last_s = T3;
      default:                          last_s = T2;
    endcase
  end

  // Step sequencer; stop only matters where an instruction would otherwise re-enter T0.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r <= T0;
    end else begin
      case (state_r)
        T0: state_r <= T1;
        T1: state_r <= T2;
        T2: begin
          if (cls_s == C_HALT)     state_r <= HALT;
          else if (cls_s == C_NOP) state_r <= stop ? PAUSE : T0;
          else                     state_r <= T3;
        end
        T3, T4, T5, T6, T7: begin
          if (state_r == last_s || state_r == T7) state_r <= stop ? PAUSE : T0;
          else                                    state_r <= state_t'(state_r + 4'd1);
        end
        HALT:    state_r <= HALT;
        PAUSE:   state_r <= stop ? PAUSE : T0;
        default: state_r <= T0;
      endcase
    end
  end

  // Strobe decode from state and IR; CON is consulted only in the branch T6 step.
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout}                                    = 6'd0;
    {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin}   = 10'd0;
    {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout}    = 8'd0;
    {Read, Write, IncPC}                                                 = 3'd0;
    run    = 1'b0;
    opcode = op_s;
    if (clear) begin
      opcode = 5'd0;
    end else begin
      case (state_r)
        T0: begin
          run = 1'b1; opcode = ADD_OP;
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        end
        T1: begin
          run = 1'b1; opcode = ADD_OP;
          Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        end
        T2: begin
          run = 1'b1; opcode = ADD_OP;
          MDRout = 1'b1; IRin = 1'b1;
        end
        T3: begin
          run = 1'b1;
          case (cls_s)
            C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            C_MULDIV:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_NEGNOT:          begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
            C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            C_JAL:             begin PCout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_IN:              begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_OUT:             begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            C_MFHI:            begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_MFLO:            begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default:           run = 1'b1;
          endcase
        end
        T4: begin
          run = 1'b1;
          case (cls_s)
            C_ALU:             begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
            C_IMM:             begin Cout = 1'b1; Zin = 1'b1; end
            C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; opcode = ADD_OP; end
            C_MULDIV:          begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
            C_NEGNOT:          begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
            C_JAL:             begin Grb = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default:           run = 1'b1;
          endcase
        end
        T5: begin
          run = 1'b1;
          case (cls_s)
            C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
            C_MULDIV:            begin Zlowout = 1'b1; LOin = 1'b1; end
            C_BR:                begin Cout = 1'b1; Zin = 1'b1; opcode = ADD_OP; end
            default:             run = 1'b1;
          endcase
        end
        T6: begin
          run = 1'b1;
          case (cls_s)
            C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
            C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
            C_BR: begin
              if (CON) begin
                Zlowout = 1'b1; PCin = 1'b1;
              end else begin
                PCin = 1'b0;
              end
            end
            default:  run = 1'b1;
          endcase
        end
        T7: begin
          run = 1'b1;
          case (cls_s)
            C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_ST:    Write = 1'b1;
            default: run = 1'b1;
          endcase
        end
        default: run = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, hand-written stop/halt sequences,
// then random instruction streams checked against a step-list model of the controller.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, CON, stop;
  logic [31:0] IR;
  logic        run, Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin;
  logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout;
  logic        Read, Write, IncPC;
  logic [4:0]  opcode;
  logic [26:0] obs;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .stop(stop), .run(run),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .Read(Read), .Write(Write), .IncPC(IncPC), .opcode(opcode)
  );

  assign obs = {IncPC, Write, Read, Cout, InPortout, LOout, HIout, Zlowout, Zhighout,
                MDRout, PCout, CONin, OutPortin, LOin, HIin, Zin, Yin, MDRin, MARin,
                IRin, PCin, BAout, Rout, Rin, Grc, Grb, Gra};

  localparam logic [26:0] GRA = 27'd1 << 0,  GRB = 27'd1 << 1,  GRC = 27'd1 << 2;
  localparam logic [26:0] RIN = 27'd1 << 3,  ROUT = 27'd1 << 4, BAOUT = 27'd1 << 5;
  localparam logic [26:0] PCIN = 27'd1 << 6, IRIN = 27'd1 << 7, MARIN = 27'd1 << 8;
  localparam logic [26:0] MDRIN = 27'd1 << 9, YIN = 27'd1 << 10, ZIN = 27'd1 << 11;
  localparam logic [26:0] HIIN = 27'd1 << 12, LOIN = 27'd1 << 13, OUTPIN = 27'd1 << 14;
  localparam logic [26:0] CONIN = 27'd1 << 15, PCOUT = 27'd1 << 16, MDROUT = 27'd1 << 17;
  localparam logic [26:0] ZHI = 27'd1 << 18, ZLO = 27'd1 << 19, HIOUT = 27'd1 << 20;
  localparam logic [26:0] LOOUT = 27'd1 << 21, INPOUT = 27'd1 << 22, COUT = 27'd1 << 23;
  localparam logic [26:0] READ = 27'd1 << 24, WRITE = 27'd1 << 25, INCPC = 27'd1 << 26;
  localparam logic [26:0] F0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [26:0] F1 = ZLO | PCIN | READ | MDRIN;
  localparam logic [26:0] F2 = MDROUT | IRIN;
  localparam logic [4:0]  ADDC = 5'b00011;
  localparam logic [31:0] IR_ADD = 32'h19198000, IR_LD = 32'h00800005;
  localparam logic [31:0] IR_BR = 32'h98000000, IR_HALT = 32'hD8000000;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 = sequencing at step k (0..2 fetch, 3.. execute), 1 = halted, 2 = paused.
  int m_mode = 0;
  int m_k = 0;

  // Classes: 0 alu 1 imm 2 ldi 3 ld 4 st 5 muldiv 6 negnot 7 br 8 jr 9 jal 10 in 11 out
  // 12 mfhi 13 mflo 14 halt 15 nop/undefined.
  function automatic int cls_of(input logic [4:0] op);
    int v;
    v = op;
    if (v == 27) return 14;
    if (v == 0) return 3;
    if (v == 1) return 2;
    if (v == 2) return 4;
    if (v >= 3 && v <= 11) return 0;
    if (v >= 12 && v <= 14) return 1;
    if (v == 15 || v == 16) return 5;
    if (v == 17 || v == 18) return 6;
    if (v >= 19 && v <= 25) return v - 12;
    return 15;
  endfunction

  function automatic int exec_len(input int c);
    int lens [16] = '{3, 3, 3, 5, 5, 4, 2, 4, 1, 2, 1, 1, 1, 1, 0, 0};
    return lens[c];
  endfunction

  function automatic logic [26:0] exec_mask(input int c, input int e, input logic con);
    case (c)
      0: return (e == 0) ? GRB|ROUT|YIN : (e == 1) ? GRC|ROUT|ZIN : ZLO|GRA|RIN;
      1: return (e == 0) ? GRB|ROUT|YIN : (e == 1) ? COUT|ZIN : ZLO|GRA|RIN;
      2: return (e == 0) ? GRB|BAOUT|YIN : (e == 1) ? COUT|ZIN : ZLO|GRA|RIN;
      3: return (e == 0) ? GRB|BAOUT|YIN : (e == 1) ? COUT|ZIN : (e == 2) ? ZLO|MARIN :
                (e == 3) ? READ|MDRIN : MDROUT|GRA|RIN;
      4: return (e == 0) ? GRB|BAOUT|YIN : (e == 1) ? COUT|ZIN : (e == 2) ? ZLO|MARIN :
                (e == 3) ? GRA|ROUT|MDRIN : WRITE;
      5: return (e == 0) ? GRA|ROUT|YIN : (e == 1) ? GRB|ROUT|ZIN : (e == 2) ? ZLO|LOIN : ZHI|HIIN;
      6: return (e == 0) ? GRB|ROUT|ZIN : ZLO|GRA|RIN;
      7: return (e == 0) ? GRA|ROUT|CONIN : (e == 1) ? PCOUT|YIN : (e == 2) ? COUT|ZIN :
                (con ? ZLO|PCIN : 27'd0);
      8: return GRA|ROUT|PCIN;
      9: return (e == 0) ? PCOUT|GRA|RIN : GRB|ROUT|PCIN;
      10: return INPOUT|GRA|RIN;
      11: return GRA|ROUT|OUTPIN;
      12: return HIOUT|GRA|RIN;
      13: return LOOUT|GRA|RIN;
      default: return 27'd0;
    endcase
  endfunction

  function automatic logic [32:0] ex(input logic r, input logic [4:0] o, input logic [26:0] m);
    return {r, o, m};
  endfunction

  function automatic logic [32:0] model_out(input logic clr, input logic [4:0] op, input logic con);
    int c;
    int e;
    logic [4:0] o;
    c = cls_of(op);
    if (clr) return 33'd0;
    if (m_mode != 0) return ex(1'b0, op, 27'd0);
    if (m_k == 0) return ex(1'b1, ADDC, F0);
    if (m_k == 1) return ex(1'b1, ADDC, F1);
    if (m_k == 2) return ex(1'b1, ADDC, F2);
    e = m_k - 3;
    o = op;
    if ((c == 2 || c == 3 || c == 4) && e == 1) o = ADDC;
    if (c == 7 && e == 2) o = ADDC;
    return ex(1'b1, o, exec_mask(c, e, con));
  endfunction

  task automatic model_step(input logic clr, input logic stp, input logic [4:0] op);
    int c;
    c = cls_of(op);
    if (clr) begin
      m_mode = 0; m_k = 0;
    end else if (m_mode == 2) begin
      if (!stp) begin m_mode = 0; m_k = 0; end
    end else if (m_mode == 0) begin
      if (m_k == 2 && c == 14) m_mode = 1;
      else if (m_k == 2 + exec_len(c)) begin
        if (stp) m_mode = 2;
        m_k = 0;
      end else m_k = m_k + 1;
    end
  endtask

  task automatic apply(input logic clr, input logic stp, input logic con, input logic [31:0] ir,
                       input logic [32:0] exp, input string tag);
    @(negedge clock);
    clear = clr; stop = stp; CON = con; IR = ir;
    #1;
    checks++;
    if ({run, opcode, obs} !== exp || (Read && Write)) begin
      failures++;
      $display("FAIL %s: got run=%b opcode=%h strobes=%h rd=%b wr=%b, expected run=%b opcode=%h strobes=%h",
               tag, run, opcode, obs, Read, Write, exp[32], exp[31:27], exp[26:0]);
    end
    @(posedge clock);
    model_step(clr, stp, ir[31:27]);
  endtask

  typedef struct {
    logic        clr, stp, con;
    logic [31:0] ir;
    logic [32:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input logic clr, input logic stp, input logic con, input logic [31:0] ir,
                      input logic [32:0] e);
    vec_t v;
    v.clr = clr; v.stp = stp; v.con = con; v.ir = ir; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rir;
    logic rclr, rstp, rcon;
    clear = 1'b1; stop = 1'b0; CON = 1'b0; IR = 32'd0;

    // Reset then add, ld, and both branch outcomes, each returning to T0.
    addv(1, 0, 0, 32'd0, 33'd0);
    addv(1, 0, 0, 32'd0, 33'd0);
    addv(0, 0, 0, 32'd0,  ex(1, ADDC, F0));
    addv(0, 0, 0, IR_ADD, ex(1, ADDC, F1));
    addv(0, 0, 0, IR_ADD, ex(1, ADDC, F2));
    addv(0, 0, 0, IR_ADD, ex(1, ADDC, GRB|ROUT|YIN));
    addv(0, 0, 0, IR_ADD, ex(1, ADDC, GRC|ROUT|ZIN));
    addv(0, 0, 0, IR_ADD, ex(1, ADDC, ZLO|GRA|RIN));
    addv(0, 0, 0, IR_LD,  ex(1, ADDC, F0));
    addv(0, 0, 0, IR_LD,  ex(1, ADDC, F1));
    addv(0, 0, 0, IR_LD,  ex(1, ADDC, F2));
    addv(0, 0, 0, IR_LD,  ex(1, 5'd0, GRB|BAOUT|YIN));
    addv(0, 0, 0, IR_LD,  ex(1, ADDC, COUT|ZIN));
    addv(0, 0, 0, IR_LD,  ex(1, 5'd0, ZLO|MARIN));
    addv(0, 0, 0, IR_LD,  ex(1, 5'd0, READ|MDRIN));
    addv(0, 0, 0, IR_LD,  ex(1, 5'd0, MDROUT|GRA|RIN));
    for (int pass = 0; pass < 2; pass++) begin
      addv(0, 0, 0, IR_BR, ex(1, ADDC, F0));
      addv(0, 0, 0, IR_BR, ex(1, ADDC, F1));
      addv(0, 0, 0, IR_BR, ex(1, ADDC, F2));
      addv(0, 0, 0, IR_BR, ex(1, 5'h13, GRA|ROUT|CONIN));
      addv(0, 0, 0, IR_BR, ex(1, 5'h13, PCOUT|YIN));
      addv(0, 0, 0, IR_BR, ex(1, ADDC, COUT|ZIN));
      addv(0, 0, pass[0], IR_BR, ex(1, 5'h13, (pass == 1) ? ZLO|PCIN : 27'd0));
    end
    addv(0, 0, 0, IR_ADD, ex(1, ADDC, F0));
    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].clr, vecs[i].stp, vecs[i].con, vecs[i].ir, vecs[i].exp, $sformatf("vec%0d", i));

    // stop raised mid-add: instruction completes, then PAUSE until stop drops.
    apply(1, 0, 0, IR_ADD, 33'd0, "stop_clear");
    apply(0, 0, 0, IR_ADD, ex(1, ADDC, F0), "stop_t0");
    apply(0, 0, 0, IR_ADD, ex(1, ADDC, F1), "stop_t1");
    apply(0, 0, 0, IR_ADD, ex(1, ADDC, F2), "stop_t2");
    apply(0, 0, 0, IR_ADD, ex(1, ADDC, GRB|ROUT|YIN), "stop_t3");
    apply(0, 1, 0, IR_ADD, ex(1, ADDC, GRC|ROUT|ZIN), "stop_t4");
    apply(0, 1, 0, IR_ADD, ex(1, ADDC, ZLO|GRA|RIN), "stop_t5");
    apply(0, 1, 0, IR_ADD, ex(0, ADDC, 27'd0), "pause_hold");
    apply(0, 0, 0, IR_ADD, ex(0, ADDC, 27'd0), "pause_release");
    apply(0, 0, 0, IR_ADD, ex(1, ADDC, F0), "pause_t0");

    // HALT parks the sequencer until clear.
    apply(1, 0, 0, IR_HALT, 33'd0, "halt_clear");
    apply(0, 0, 0, IR_HALT, ex(1, ADDC, F0), "halt_t0");
    apply(0, 0, 0, IR_HALT, ex(1, ADDC, F1), "halt_t1");
    apply(0, 0, 0, IR_HALT, ex(1, ADDC, F2), "halt_t2");
    for (int i = 0; i < 20; i++)
      apply(0, i[0], 0, IR_HALT, ex(0, 5'h1B, 27'd0), $sformatf("halt_park%0d", i));
    apply(1, 0, 0, IR_HALT, 33'd0, "halt_exit_clear");
    apply(0, 0, 0, IR_ADD, ex(1, ADDC, F0), "halt_exit_t0");

    // Random instruction stream against the model; IR only changes at instruction start.
    rir = IR_ADD;
    for (int i = 0; i < 1500; i++) begin
      rclr = ($urandom_range(0, 39) == 0);
      rstp = ($urandom_range(0, 3) == 0);
      rcon = $urandom_range(0, 1) == 1;
      if (m_mode != 0 || m_k == 0) begin
        rir = $urandom;
        if (rir[31:27] == 5'd27 && $urandom_range(0, 3) != 0) rir[27] = 1'b0;
      end
      apply(rclr, rstp, rcon, rir, model_out(rclr, rir[31:27], rcon), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
